mem_dma: RTL and testbench

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma.sv | 141 ++++++++++++++
 tb/tb_mem_dma.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma.sv
// Single-channel memory-to-memory DMA that sits between a CPU port and a memory bank.
// Optional fill mode (constant pattern writes) is enabled by defining DMA_FILL_EN.
`ifndef DATA_WORD_SIZE
`define DATA_WORD_SIZE 8
`endif
`ifndef DATA_ADDR_SIZE
`define DATA_ADDR_SIZE 8
`endif

module mem_dma #(
   parameter int unsigned word_size = `DATA_WORD_SIZE,
   parameter int unsigned addr_size = `DATA_ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [addr_size-1:0] src,
   input  logic [addr_size-1:0] dst,
   input  logic [addr_size-1:0] len,
   input  logic                 fill,
   input  logic [word_size-1:0] fill_val,
   output logic                 busy,
   output logic                 done,
   input  logic                 cpu_w_en,
   input  logic [addr_size-1:0] cpu_addr,
   input  logic [word_size-1:0] cpu_d_in,
   output logic                 cpu_stall,
   output logic                 mem_w_en,
   output logic [addr_size-1:0] mem_addr,
   output logic [word_size-1:0] mem_d_in,
   input  logic [word_size-1:0] mem_d_out
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t               state, state_nxt;
   logic [addr_size-1:0] src_ptr, src_nxt;
   logic [addr_size-1:0] dst_ptr, dst_nxt;
   logic [addr_size-1:0] count, count_nxt;
   logic [word_size-1:0] data_reg, data_nxt;
   logic                 fill_start;
   logic                 fill_mode;
   logic [word_size-1:0] wr_data;

`ifdef DMA_FILL_EN
   logic                 fill_reg;
   logic [word_size-1:0] fill_val_reg;

   // Fill configuration is captured on the same start edge as the pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_reg     <= 1'b0;
         fill_val_reg <= '0;
      end else if (state == IDLE && start) begin
         fill_reg     <= fill;
         fill_val_reg <= fill_val;
      end
   end

   assign fill_start = fill;
   assign fill_mode  = fill_reg;
   assign wr_data    = fill_reg ? fill_val_reg : data_reg;
`else
   logic fill_unused;

   assign fill_unused = ^{fill, fill_val};
   assign fill_start  = 1'b0;
   assign fill_mode   = 1'b0;
   assign wr_data     = data_reg;
`endif

   assign cpu_stall = busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         src_ptr  <= '0;
         dst_ptr  <= '0;
         count    <= '0;
         data_reg <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         src_ptr  <= src_nxt;
         dst_ptr  <= dst_nxt;
         count    <= count_nxt;
         data_reg <= data_nxt;
         busy     <= (state_nxt == READ) || (state_nxt == WRITE);
         done     <= (state_nxt == DONE);
      end
   end

   // Memory port belongs to the CPU except while a transfer is moving data
   always_comb begin
      state_nxt = state;
      src_nxt   = src_ptr;
      dst_nxt   = dst_ptr;
      count_nxt = count;
      data_nxt  = data_reg;
      mem_w_en  = cpu_w_en;
      mem_addr  = cpu_addr;
      mem_d_in  = cpu_d_in;
      case (state)
         IDLE: begin
            if (start) begin
               src_nxt   = src;
               dst_nxt   = dst;
               count_nxt = len;
               if (len == '0)      state_nxt = DONE;
               else if (fill_start) state_nxt = WRITE;
               else                 state_nxt = READ;
            end
         end
         READ: begin
            mem_w_en  = 1'b0;
            mem_addr  = src_ptr;
            data_nxt  = mem_d_out;
            state_nxt = WRITE;
         end
         WRITE: begin
            mem_w_en  = 1'b1;
            mem_addr  = dst_ptr;
            mem_d_in  = wr_data;
            src_nxt   = src_ptr + addr_size'(1);
            dst_nxt   = dst_ptr + addr_size'(1);
            count_nxt = count - addr_size'(1);
            if (count == addr_size'(1)) state_nxt = DONE;
            else if (fill_mode)         state_nxt = WRITE;
            else                        state_nxt = READ;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: expected memory writes and done pulses are queued by the
// stimulus and consumed by a monitor that watches the memory port.
module tb_mem_dma;

   localparam int unsigned W = 8;
   localparam int unsigned A = 8;

   logic         clk, rst_n, start, fill, busy, done;
   logic [A-1:0] src, dst, len, cpu_addr, mem_addr;
   logic [W-1:0] fill_val, cpu_d_in, mem_d_in, mem_d_out;
   logic         cpu_w_en, cpu_stall, mem_w_en;
   logic [W-1:0] mem [0:255];

   typedef struct packed {
      logic         is_done;
      logic [A-1:0] addr;
      logic [W-1:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   logic [15:0] preload [22] = '{
      16'h10A1, 16'h11B2, 16'h12C3, 16'h4000, 16'h4100, 16'h4200, 16'h5000, 16'h2011,
      16'h2122, 16'h2233, 16'h305C, 16'h316D, 16'h7000, 16'h7100, 16'h9000, 16'hFF9E,
      16'h004F, 16'hFE00, 16'h0100, 16'h6000, 16'h6100, 16'h6200};

   mem_dma #(.word_size(W), .addr_size(A)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
      .fill(fill), .fill_val(fill_val), .busy(busy), .done(done),
      .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr), .cpu_d_in(cpu_d_in), .cpu_stall(cpu_stall),
      .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory bank: combinational read, synchronous write
   assign mem_d_out = mem[mem_addr];
   always @(posedge clk) if (mem_w_en) mem[mem_addr] <= mem_d_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic sb_take(input logic is_done);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL sb_unexpected: got done=%0b addr=%0h data=%0h, required no event",
                  is_done, mem_addr, mem_d_in);
      end else begin
         e = exp_q.pop_front();
         if (e.is_done !== is_done ||
             (!is_done && (e.addr !== mem_addr || e.data !== mem_d_in))) begin
            fails++;
            $display("FAIL sb_event: got done=%0b addr=%0h data=%0h, required done=%0b addr=%0h data=%0h",
                     is_done, mem_addr, mem_d_in, e.is_done, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_w_en) sb_take(1'b0);
         if (done)     sb_take(1'b1);
      end
   end

   task automatic push_wr(input logic [A-1:0] a, input logic [W-1:0] d);
      exp_q.push_back('{is_done: 1'b0, addr: a, data: d});
   endtask

   task automatic push_done();
      exp_q.push_back('{is_done: 1'b1, addr: '0, data: '0});
   endtask

   task automatic cpu_write(input logic [A-1:0] a, input logic [W-1:0] d);
      push_wr(a, d);
      @(posedge clk); #1;
      cpu_w_en = 1'b1; cpu_addr = a; cpu_d_in = d;
      @(posedge clk); #1;
      cpu_w_en = 1'b0;
   endtask

   task automatic xfer(input logic [A-1:0] s, input logic [A-1:0] d, input logic [A-1:0] n,
                       input logic f, input logic [W-1:0] fv, input int exp_busy,
                       input bit cpu_hold, input bit restart);
      int busy_cnt = 0;
      int cyc = 0;
      bit seen = 0;
      @(posedge clk); #1;
      start = 1'b1; src = s; dst = d; len = n; fill = f; fill_val = fv;
      @(posedge clk); #1;
      start = 1'b0; src = ~s; dst = ~d; len = ~n; fill = ~f; fill_val = ~fv;
      if (cpu_hold) begin
         cpu_w_en = 1'b1; cpu_addr = 8'h40; cpu_d_in = 8'hEE;
      end
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (busy) begin
            busy_cnt++;
            if (cpu_hold) check("cpu_stall", cpu_stall, 1);
            if (busy_cnt == exp_busy) cpu_w_en = 1'b0;
            if (restart && busy_cnt == 2) begin start = 1'b1; dst = 8'h90; end
            if (restart && busy_cnt == 3) start = 1'b0;
         end
         if (done) seen = 1;
      end
      check("xfer_done_seen", seen, 1);
      check("xfer_busy_cycles", busy_cnt, exp_busy);
      check("xfer_done_cycle", cyc, exp_busy + 1);
      repeat (3) @(posedge clk);
      #1 check("sb_drained", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; fill = 1'b0; fill_val = '0;
      cpu_w_en = 1'b0; cpu_addr = 8'h33; cpu_d_in = 8'h44;
      #2 rst_n = 1'b0;
      #10;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall", cpu_stall, 0);
      check("rst_pass_addr", mem_addr, 8'h33);
      check("rst_pass_data", mem_d_in, 8'h44);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 22; i++) cpu_write(preload[i][15:8], preload[i][7:0]);
      check("preload_drained", exp_q.size(), 0);

      // Copy with CPU write contention at the destination
      push_wr(8'h40, 8'hA1); push_wr(8'h41, 8'hB2); push_wr(8'h42, 8'hC3); push_done();
      xfer(8'h10, 8'h40, 8'd3, 1'b0, 8'h00, 6, 1, 0);
      check("copy_m40", mem[8'h40], 8'hA1);
      check("copy_m41", mem[8'h41], 8'hB2);
      check("copy_m42", mem[8'h42], 8'hC3);
      cpu_write(8'h40, 8'h77);
      check("cpu_after_done", mem[8'h40], 8'h77);

      // Zero-length no-op
      push_done();
      xfer(8'h00, 8'h50, 8'd0, 1'b0, 8'h00, 0, 0, 0);
      check("len0_m50", mem[8'h50], 8'h00);

      // Overlapping ascending copy replicates the first source word
      push_wr(8'h21, 8'h11); push_wr(8'h22, 8'h11); push_done();
      xfer(8'h20, 8'h21, 8'd2, 1'b0, 8'h00, 4, 0, 0);
      check("overlap_m22", mem[8'h22], 8'h11);

      // Second start while busy is ignored
      push_wr(8'h70, 8'h5C); push_wr(8'h71, 8'h6D); push_done();
      xfer(8'h30, 8'h70, 8'd2, 1'b0, 8'h00, 4, 0, 1);
      check("restart_m71", mem[8'h71], 8'h6D);
      check("restart_m90", mem[8'h90], 8'h00);

`ifdef DMA_FILL_EN
      push_wr(8'hFE, 8'h5A); push_wr(8'hFF, 8'h5A); push_wr(8'h00, 8'h5A); push_wr(8'h01, 8'h5A);
      push_done();
      xfer(8'h00, 8'hFE, 8'd4, 1'b1, 8'h5A, 4, 0, 0);
      check("fill_m01", mem[8'h01], 8'h5A);
`else
      // fill request ignored: copy with source wrap
      push_wr(8'hFE, 8'h9E); push_wr(8'hFF, 8'h4F); push_done();
      xfer(8'hFF, 8'hFE, 8'd2, 1'b1, 8'h5A, 4, 0, 0);
      check("nofill_mFF", mem[8'hFF], 8'h4F);
`endif

      // Reset during the second WRITE aborts the transfer
      push_wr(8'h60, 8'hA1);
      @(posedge clk); #1;
      start = 1'b1; src = 8'h10; dst = 8'h60; len = 8'd3; fill = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("abort_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_stall", cpu_stall, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("abort_m60", mem[8'h60], 8'hA1);
      check("abort_m61", mem[8'h61], 8'h00);
      check("abort_m62", mem[8'h62], 8'h00);
      check("abort_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
